// File: rtl/io_display_ctrl.sv
// IO output peripheral: LED latch plus a scanned 8-digit hex display.
// Store strobes from the IO decoder land here; outputs drive board pins.
module io_display_ctrl #(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DIGITS   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ioWrite,
  input  logic        LEDCtrl,
  input  logic        SegCtrl,
  input  logic [1:0]  addr_low,
  input  logic [15:0] write_data,
  output logic [23:0] LED,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out
);

  localparam logic [31:0] LP_PLAST = 32'(SCAN_DIV - 1);
  localparam logic [2:0]  LP_ILAST = 3'(DIGITS - 1);

  logic [23:0] r_led;
  logic [31:0] r_segv;
  logic [31:0] r_pcnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_an;
  logic [7:0]  r_seg;

  logic        w_led_lo;
  logic        w_led_hi;
  logic        w_seg_lo;
  logic        w_seg_hi;
  logic        w_wrap;
  logic [3:0]  w_nib;
  logic [7:0]  w_an;
  logic [7:0]  w_one;

  function automatic logic [7:0] hex7(input logic [3:0] n);
    logic [7:0] p;
    unique case (n)
      4'h0: p = 8'hC0;
      4'h1: p = 8'hF9;
      4'h2: p = 8'hA4;
      4'h3: p = 8'hB0;
      4'h4: p = 8'h99;
      4'h5: p = 8'h92;
      4'h6: p = 8'h82;
      4'h7: p = 8'hF8;
      4'h8: p = 8'h80;
      4'h9: p = 8'h90;
      4'hA: p = 8'h88;
      4'hB: p = 8'h83;
      4'hC: p = 8'hC6;
      4'hD: p = 8'hA1;
      4'hE: p = 8'h86;
      4'hF: p = 8'h8E;
    endcase
    return p;
  endfunction

  // LED select wins over segment select when both are asserted
  assign w_led_lo = ioWrite & LEDCtrl & (addr_low == 2'd0);
  assign w_led_hi = ioWrite & LEDCtrl & (addr_low == 2'd2);
  assign w_seg_lo = ioWrite & SegCtrl & ~LEDCtrl & (addr_low == 2'd0);
  assign w_seg_hi = ioWrite & SegCtrl & ~LEDCtrl & (addr_low == 2'd2);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_led  <= '0;
      r_segv <= '0;
    end else begin
      unique case (1'b1)
        w_led_lo: r_led[15:0]   <= write_data;
        w_led_hi: r_led[23:16]  <= write_data[7:0];
        w_seg_lo: r_segv[15:0]  <= write_data;
        w_seg_hi: r_segv[31:16] <= write_data;
        default: ;
      endcase
    end
  end

  assign w_wrap = (r_pcnt == LP_PLAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pcnt <= '0;
      r_idx  <= '0;
    end else if (w_wrap) begin
      r_pcnt <= '0;
      r_idx  <= (r_idx == LP_ILAST) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_pcnt <= r_pcnt + 32'd1;
    end
  end

  // Outputs lag idx by one edge, so each slot stays SCAN_DIV wide
  assign w_one = 8'd1;
  assign w_an  = ~(w_one << r_idx);
  assign w_nib = r_segv[{r_idx, 2'b00} +: 4];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_an  <= 8'hFF;
      r_seg <= 8'hFF;
    end else begin
      r_an  <= w_an;
      r_seg <= hex7(w_nib);
    end
  end

  assign LED     = r_led;
  assign seg_an  = r_an;
  assign seg_out = r_seg;

endmodule

// File: tb/tb_io_display_ctrl.sv
// Bench for io_display_ctrl: vector table, corner sequences, random
// traffic against a slot-arithmetic model; 8-digit and 3-digit builds.
module tb_io_display_ctrl;

  localparam int SD = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        ioWrite;
  logic        LEDCtrl;
  logic        SegCtrl;
  logic [1:0]  addr_low;
  logic [15:0] write_data;
  logic [23:0] LED;
  logic [7:0]  seg_an;
  logic [7:0]  seg_out;
  logic [23:0] LED3;
  logic [7:0]  seg_an3;
  logic [7:0]  seg_out3;

  int checks   = 0;
  int failures = 0;

  int          e;
  logic [23:0] m_led;
  logic [31:0] m_segv;
  logic [7:0]  lut [16];

  typedef struct {
    logic        wr;
    logic        ls;
    logic        ss;
    logic [1:0]  a;
    logic [15:0] d;
    logic [23:0] led;
  } vec_t;

  vec_t vecs [8];

  io_display_ctrl #(.SCAN_DIV(SD), .DIGITS(8)) dut (
    .clock(clock), .reset(reset), .ioWrite(ioWrite),
    .LEDCtrl(LEDCtrl), .SegCtrl(SegCtrl), .addr_low(addr_low),
    .write_data(write_data), .LED(LED), .seg_an(seg_an),
    .seg_out(seg_out)
  );

  io_display_ctrl #(.SCAN_DIV(SD), .DIGITS(3)) dut3 (
    .clock(clock), .reset(reset), .ioWrite(ioWrite),
    .LEDCtrl(LEDCtrl), .SegCtrl(SegCtrl), .addr_low(addr_low),
    .write_data(write_data), .LED(LED3), .seg_an(seg_an3),
    .seg_out(seg_out3)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic mreset();
    e      = 0;
    m_led  = '0;
    m_segv = '0;
  endtask

  // One clock edge with the given store inputs, then compare to model
  task automatic cyc(input logic w, input logic l, input logic s,
                     input logic [1:0] a, input logic [15:0] d);
    int i8;
    int i3;
    logic [7:0] one;
    logic [7:0] ea8, es8, ea3, es3;
    ioWrite = w; LEDCtrl = l; SegCtrl = s;
    addr_low = a; write_data = d;
    @(posedge clock);
    one = 8'd1;
    i8  = (e / SD) % 8;
    i3  = (e / SD) % 3;
    ea8 = ~(one << i8);
    es8 = lut[m_segv[4*i8 +: 4]];
    ea3 = ~(one << i3);
    es3 = lut[m_segv[4*i3 +: 4]];
    e++;
    if (w && l) begin
      if (a == 2'd0) m_led[15:0] = d;
      if (a == 2'd2) m_led[23:16] = d[7:0];
    end else if (w && s) begin
      if (a == 2'd0) m_segv[15:0] = d;
      if (a == 2'd2) m_segv[31:16] = d;
    end
    #1;
    chk("led", 32'(LED), 32'(m_led));
    chk("seg_an", 32'(seg_an), 32'(ea8));
    chk("seg_out", 32'(seg_out), 32'(es8));
    chk("seg_an3", 32'(seg_an3), 32'(ea3));
    chk("seg_out3", 32'(seg_out3), 32'(es3));
    chk("led3", 32'(LED3), 32'(m_led));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
  endtask

  initial begin
    lut = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    vecs[0] = '{1'b1, 1'b1, 1'b0, 2'd0, 16'hBEEF, 24'h00BEEF};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 2'd2, 16'h12A5, 24'hA5BEEF};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 2'd0, 16'h1234, 24'hA51234};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 2'd1, 16'hFFFF, 24'hA51234};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 2'd3, 16'hFFFF, 24'hA51234};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 2'd0, 16'hFFFF, 24'hA51234};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 2'd0, 16'h5555, 24'hA51234};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 2'd2, 16'hFF3C, 24'h3C1234};

    reset = 1'b0; ioWrite = 1'b0; LEDCtrl = 1'b0; SegCtrl = 1'b0;
    addr_low = 2'd0; write_data = 16'h0;
    mreset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_led", 32'(LED), 32'h0);
    chk("rst_an", 32'(seg_an), 32'hFF);
    chk("rst_seg", 32'(seg_out), 32'hFF);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
    chk("first_an", 32'(seg_an), 32'hFE);
    chk("first_seg", 32'(seg_out), 32'hC0);

    for (int v = 0; v < 8; v++) begin
      cyc(vecs[v].wr, vecs[v].ls, vecs[v].ss, vecs[v].a, vecs[v].d);
      chk($sformatf("vec%0d_led", v), 32'(LED), 32'(vecs[v].led));
    end

    // Scan sweep over a known value
    cyc(1'b1, 1'b0, 1'b1, 2'd0, 16'hCDEF);
    cyc(1'b1, 1'b0, 1'b1, 2'd2, 16'h89AB);
    idle(40);

    // Rewrite digit 0 while it is lit
    while ((e % (8 * SD)) != 0) idle(1);
    cyc(1'b1, 1'b0, 1'b1, 2'd0, 16'h0007);
    chk("lit_old", 32'(seg_out), 32'h8E);
    idle(1);
    chk("lit_new", 32'(seg_out), 32'hF8);
    chk("lit_an", 32'(seg_an), 32'hFE);
    idle(36);

    for (int k = 0; k < 400; k++)
      cyc(1'($urandom), 1'($urandom), 1'($urandom),
          2'($urandom), 16'($urandom));

    // Asynchronous reset mid-scan, with a write held during reset
    #2;
    ioWrite = 1'b1; LEDCtrl = 1'b1; SegCtrl = 1'b0;
    addr_low = 2'd0; write_data = 16'hFFFF;
    reset = 1'b0;
    #1;
    chk("arst_led", 32'(LED), 32'h0);
    chk("arst_an", 32'(seg_an), 32'hFF);
    chk("arst_seg", 32'(seg_out), 32'hFF);
    chk("arst_an3", 32'(seg_an3), 32'hFF);
    @(posedge clock);
    #1;
    chk("rst_wr_drop", 32'(LED), 32'h0);
    ioWrite = 1'b0;
    reset = 1'b1;
    mreset();
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
    chk("rel_an", 32'(seg_an), 32'hFE);
    chk("rel_seg", 32'(seg_out), 32'hC0);
    idle(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
